// File: rtl/collision_scheduler.sv
// Collision scheduler: once per video frame, reads the bullet-grid bit under
// the user sprite and then under the enemy sprite through a shared one-cycle
// latency read port, then applies damage, invulnerability frames and the
// game-over decision.
module collision_scheduler #(
    parameter logic [3:0] HEALTH_INIT  = 4'd3,
    parameter logic [7:0] IFRAME_TICKS = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [7:0]  user_x,
    input  logic [6:0]  user_y,
    input  logic [7:0]  enemy_x,
    input  logic [6:0]  enemy_y,
    output logic        grid_rd_en,
    output logic [14:0] grid_addr,
    input  logic        grid_rd_data,
    output logic [3:0]  user_health,
    output logic [3:0]  enemy_health,
    output logic        user_hit,
    output logic        enemy_hit,
    output logic        busy,
    output logic        game_over,
    output logic [1:0]  result
);

    localparam int unsigned GRID_W   = 160;
    localparam int unsigned GRID_H   = 120;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned HEALTH_W = 4;
    localparam int unsigned IFRAME_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_U  = 3'd1,
        WAIT_U = 3'd2,
        REQ_E  = 3'd3,
        WAIT_E = 3'd4,
        UPDATE = 3'd5
    } state_t;

    state_t              state;
    logic [7:0]          enemy_x_snap;
    logic [6:0]          enemy_y_snap;
    logic                user_valid_snap;
    logic                user_flag;
    logic                enemy_flag;
    logic [IFRAME_W-1:0] user_iframe;
    logic [IFRAME_W-1:0] enemy_iframe;

    logic                user_in_valid;
    logic                enemy_snap_valid;
    logic [ADDR_W-1:0]   user_in_addr;
    logic [ADDR_W-1:0]   enemy_snap_addr;
    logic                user_count;
    logic                enemy_count;
    logic [HEALTH_W-1:0] user_health_next;
    logic [HEALTH_W-1:0] enemy_health_next;

    // Row-major bit index; every operand is widened to 15 bits before the multiply.
    function automatic logic [ADDR_W-1:0] grid_index(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'(x) * ADDR_W'(GRID_H) + ADDR_W'(y);
    endfunction

    // Coordinate range checks and read addresses for both sprites.
    always_comb begin
        user_in_valid    = (32'(user_x) < GRID_W) && (32'(user_y) < GRID_H);
        enemy_snap_valid = (32'(enemy_x_snap) < GRID_W) && (32'(enemy_y_snap) < GRID_H);
        user_in_addr     = grid_index(user_x, user_y);
        enemy_snap_addr  = grid_index(enemy_x_snap, enemy_y_snap);
    end

    // Damage decision per entity: a hit only counts while not invulnerable.
    always_comb begin
        user_count        = user_flag && (user_iframe == '0);
        enemy_count       = enemy_flag && (enemy_iframe == '0);
        user_health_next  = user_health;
        enemy_health_next = enemy_health;
        if (user_count && (user_health != '0)) begin
            user_health_next = user_health - HEALTH_W'(1);
        end
        if (enemy_count && (enemy_health != '0)) begin
            enemy_health_next = enemy_health - HEALTH_W'(1);
        end
    end

    // Sequencer with all outputs registered alongside the state transitions.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            state           <= IDLE;
            enemy_x_snap    <= '0;
            enemy_y_snap    <= '0;
            user_valid_snap <= 1'b0;
            user_flag       <= 1'b0;
            enemy_flag      <= 1'b0;
            user_iframe     <= '0;
            enemy_iframe    <= '0;
            grid_rd_en      <= 1'b0;
            grid_addr       <= '0;
            user_health     <= HEALTH_INIT;
            enemy_health    <= HEALTH_INIT;
            user_hit        <= 1'b0;
            enemy_hit       <= 1'b0;
            busy            <= 1'b0;
            game_over       <= 1'b0;
            result          <= 2'b00;
        end else begin
            grid_rd_en <= 1'b0;
            grid_addr  <= '0;
            user_hit   <= 1'b0;
            enemy_hit  <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick && !game_over) begin
                        enemy_x_snap    <= enemy_x;
                        enemy_y_snap    <= enemy_y;
                        user_valid_snap <= user_in_valid;
                        grid_rd_en      <= user_in_valid;
                        grid_addr       <= user_in_valid ? user_in_addr : '0;
                        busy            <= 1'b1;
                        state           <= REQ_U;
                    end
                end
                REQ_U: begin
                    state <= WAIT_U;
                end
                WAIT_U: begin
                    user_flag  <= grid_rd_data && user_valid_snap;
                    grid_rd_en <= enemy_snap_valid;
                    grid_addr  <= enemy_snap_valid ? enemy_snap_addr : '0;
                    state      <= REQ_E;
                end
                REQ_E: begin
                    state <= WAIT_E;
                end
                WAIT_E: begin
                    enemy_flag <= grid_rd_data && enemy_snap_valid;
                    state      <= UPDATE;
                end
                UPDATE: begin
                    user_health  <= user_health_next;
                    enemy_health <= enemy_health_next;
                    user_hit     <= user_count;
                    enemy_hit    <= enemy_count;
                    if (user_count) begin
                        user_iframe <= IFRAME_TICKS;
                    end else if (user_iframe != '0) begin
                        user_iframe <= user_iframe - IFRAME_W'(1);
                    end
                    if (enemy_count) begin
                        enemy_iframe <= IFRAME_TICKS;
                    end else if (enemy_iframe != '0) begin
                        enemy_iframe <= enemy_iframe - IFRAME_W'(1);
                    end
                    // Result bits: {user dead, enemy dead}; both set means a draw.
                    if ((user_health_next == '0) || (enemy_health_next == '0)) begin
                        game_over <= 1'b1;
                        result    <= {user_health_next == '0, enemy_health_next == '0};
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 SHALL have parameter HEALTH_INIT, default 3: health loaded at reset/start (4-bit).
REQ-002 SHALL have parameter IFRAME_TICKS, default 30: frames of immunity after a counted hit (8-bit).
REQ-003 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: synchronous game restart, same effect as rst.
REQ-006 SHALL have port frame_tick  input  1: one-cycle pulse, once per video frame.
REQ-007 SHALL have ports user_x/enemy_x  input  8 and user_y/enemy_y  input  7: sprite coordinates on the 160x120 grid.
REQ-008 SHALL have port grid_rd_en  output  1: read strobe to the shared bullet-grid port.
REQ-009 SHALL have port grid_addr  output  15: grid bit index, x*120+y.
REQ-010 SHALL have port grid_rd_data  input  1: bullet bit, valid exactly one cycle after grid_rd_en.
REQ-011 SHALL have ports user_health/enemy_health  output  4: current health.
REQ-012 SHALL have ports user_hit/enemy_hit  output  1: one-cycle pulse per counted hit.
REQ-013 SHALL have port busy  output  1: high while a check sequence is in progress.
REQ-014 SHALL have port game_over  output  1 and result  output  2: 00 none, 01 user wins, 10 enemy wins, 11 draw.

Function
REQ-015 SHALL implement FSM states IDLE, REQ_U, WAIT_U, REQ_E, WAIT_E, UPDATE.
REQ-016 IDLE: frame_tick with game_over=0 SHALL snapshot all four coordinates and go to REQ_U; otherwise stay.
REQ-017 frame_tick outside IDLE or while game_over=1 SHALL be dropped with no effect.
REQ-018 REQ_U/REQ_E SHALL drive grid_rd_en=1 and grid_addr from the snapshot for one cycle; grid_rd_en=0 in all other states.
REQ-019 WAIT_U/WAIT_E SHALL capture grid_rd_data as the hit flag for user/enemy.
REQ-020 A snapshot with x>159 or y>119 SHALL suppress grid_rd_en in its REQ state and force that hit flag to 0.
REQ-021 grid_addr SHALL be computed at 15 bits without truncation (max 19199); grid_addr=0 when grid_rd_en=0.
REQ-022 Sequence timing: tick in cycle T -> REQ_U T+1, WAIT_U T+2, REQ_E T+3, WAIT_E T+4, UPDATE T+5, IDLE T+6; busy=1 for T+1..T+5.
REQ-023 UPDATE, per entity: hit=1 and iframe=0 -> health-1 (saturate at 0), hit pulse, iframe<=IFRAME_TICKS; else if iframe>0 -> iframe-1.
REQ-024 Health, hit pulses, game_over and result SHALL all be registered and change at the end of UPDATE (visible T+6); pulses last exactly one cycle.
REQ-025 In UPDATE, if either health becomes 0: game_over<=1; result=01 enemy only, 10 user only, 11 both same cycle.
REQ-026 game_over and result SHALL remain sticky until rst or start.
REQ-027 Both entities SHALL be evaluated independently in the same UPDATE; simultaneous hits both count.

Reset
REQ-028 rst or start SHALL, next cycle: state IDLE, user/enemy_health=HEALTH_INIT, iframes 0, grid_rd_en 0, grid_addr 0, hit pulses 0, busy 0, game_over 0, result 00.
REQ-029 rst/start mid-sequence SHALL abort it with no health change; rst takes priority over frame_tick in the same cycle.

Verification
REQ-030 Bullet at user (10,20), tick at T -> grid_rd_en T+1 with grid_addr 1220; user_health 3->2 and user_hit pulse at T+6; busy high T+1..T+5.
REQ-031 IFRAME_TICKS=2, user bullet held on ticks N..N+3 -> hits counted at N and N+3 only; health 3->2->1.
REQ-032 Bullets on both sprites, both health=1 -> both reach 0 same cycle, game_over=1, result=11; later ticks ignored, busy stays 0.
REQ-033 enemy_x=200 with bullet bits all 1 -> no grid_rd_en in REQ_E, enemy_health unchanged; user still checked.
REQ-034 Second frame_tick at T+3 -> dropped, exactly one grid_rd_en pair observed; start asserted at T+4 -> IDLE at T+5, health 3/3, no hit pulses.
